// File: rtl/pipe_stage_skid_if.sv
// Valid/ready stream carrying one pipeline-stage entry (opaque data bundle plus control bundle).
// Master drives valid/data/ctrl, slave drives ready.
interface pipe_stage_skid_if #(
   parameter int DATA_W = 160,
   parameter int CTRL_W = 5
) ();
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;

   modport master (output valid, output data, output ctrl, input ready);
   modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Handshaked stage register, 1-cycle in->out latency. Backpressure: SKID_EN=1 absorbs one extra entry
// behind a registered in_ready that drops once two are held; SKID_EN=0 gives in_ready = !out_valid | out_ready.
module pipe_stage_skid #(
   parameter int DATA_W  = 160,
   parameter int CTRL_W  = 5,
   parameter bit SKID_EN = 1'b1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   pipe_stage_skid_if.slave  up,
   pipe_stage_skid_if.master dn,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic [1:0] state_q;
   logic [1:0] state_d;
   entry_t     main_q;
   entry_t     main_d;
   entry_t     skid_q;
   entry_t     in_ent;
   logic       ready;
   logic       out_valid;
   logic       in_fire;
   logic       out_fire;
   logic       stall;

   assign in_ent    = {up.ctrl, up.data};
   assign out_valid = (state_q != EMPTY);
   assign in_fire   = up.valid & ready;
   assign out_fire  = out_valid & dn.ready;
   assign stall     = out_valid & ~dn.ready;

   assign up.ready  = ready;
   assign dn.valid  = out_valid;
   assign dn.data   = main_q.data;
   assign dn.ctrl   = out_valid ? main_q.ctrl : '0;

   // Flush wins over everything: bubble out, keep data, kill the control bits.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      if (flush) begin
         state_d     = EMPTY;
         main_d.ctrl = '0;
      end else if (SKID_EN) begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d = ONE;
                  main_d  = in_ent;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_d = in_ent;
               end else if (in_fire) begin
                  state_d = FULL;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end else begin
         if (in_fire) begin
            state_d = ONE;
            main_d  = in_ent;
         end else if (out_fire) begin
            state_d = EMPTY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
      end
   end

   generate
      if (SKID_EN) begin : g_skid
         entry_t skid_r;
         logic   ready_r;
         logic   skid_load;

         // Second entry only arrives while the head is held in place.
         assign skid_load = (state_q == ONE) & in_fire & ~out_fire;

         always_ff @(posedge clk) begin
            if (reset) begin
               skid_r  <= '0;
               ready_r <= 1'b1;
            end else begin
               ready_r <= (state_d != FULL);
               if (flush) begin
                  skid_r.ctrl <= '0;
               end else if (skid_load) begin
                  skid_r <= in_ent;
               end
            end
         end

         assign skid_q = skid_r;
         assign ready  = ready_r;
      end else begin : g_noskid
         assign skid_q = '0;
         assign ready  = ~out_valid | dn.ready;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Drives three stages (skid/16-bit count, skid/4-bit count, single-entry) from one stimulus stream
// and compares each against a queue-based model of the stage's transfer rules.
module tb_pipe_stage_skid;

   typedef struct packed {
      logic [4:0]   ctrl;
      logic [159:0] data;
   } ent_t;

   typedef struct packed {
      logic         vld;
      logic         rdy;
      logic [4:0]   ctrl;
      logic [159:0] data;
      logic [15:0]  cnt;
   } obs_t;

   logic         clk;
   logic         reset;
   logic         flush;
   logic         in_valid;
   logic         out_ready;
   logic [159:0] in_data;
   logic [4:0]   in_ctrl;
   logic [15:0]  cnt0;
   logic [3:0]   cnt1;
   logic [15:0]  cnt2;

   int checks = 0;
   int failures = 0;

   pipe_stage_skid_if #(.DATA_W(160), .CTRL_W(5)) up0 ();
   pipe_stage_skid_if #(.DATA_W(160), .CTRL_W(5)) dn0 ();
   pipe_stage_skid_if #(.DATA_W(160), .CTRL_W(5)) up1 ();
   pipe_stage_skid_if #(.DATA_W(160), .CTRL_W(5)) dn1 ();
   pipe_stage_skid_if #(.DATA_W(160), .CTRL_W(5)) up2 ();
   pipe_stage_skid_if #(.DATA_W(160), .CTRL_W(5)) dn2 ();

   assign up0.valid = in_valid;  assign up0.data = in_data;  assign up0.ctrl = in_ctrl;
   assign up1.valid = in_valid;  assign up1.data = in_data;  assign up1.ctrl = in_ctrl;
   assign up2.valid = in_valid;  assign up2.data = in_data;  assign up2.ctrl = in_ctrl;
   assign dn0.ready = out_ready;
   assign dn1.ready = out_ready;
   assign dn2.ready = out_ready;

   pipe_stage_skid #(.DATA_W(160), .CTRL_W(5), .SKID_EN(1'b1), .CNT_W(16)) dut0 (
      .clk(clk), .reset(reset), .flush(flush), .up(up0), .dn(dn0), .stall_cnt(cnt0));
   pipe_stage_skid #(.DATA_W(160), .CTRL_W(5), .SKID_EN(1'b1), .CNT_W(4)) dut1 (
      .clk(clk), .reset(reset), .flush(flush), .up(up1), .dn(dn1), .stall_cnt(cnt1));
   pipe_stage_skid #(.DATA_W(160), .CTRL_W(5), .SKID_EN(1'b0), .CNT_W(16)) dut2 (
      .clk(clk), .reset(reset), .flush(flush), .up(up2), .dn(dn2), .stall_cnt(cnt2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference model: each stage is a FIFO of capacity 2 (skid) or 1 (single-entry).
   ent_t        mq0[$];
   ent_t        mq1[$];
   ent_t        mq2[$];
   int unsigned mcnt[3];

   function automatic int msize(int k);
      if (k == 0) return mq0.size();
      if (k == 1) return mq1.size();
      return mq2.size();
   endfunction

   function automatic ent_t mhead(int k);
      if (msize(k) == 0) return '0;
      if (k == 0) return mq0[0];
      if (k == 1) return mq1[0];
      return mq2[0];
   endfunction

   function automatic logic mready(int k);
      if (k == 2) return (msize(2) == 0) || out_ready;
      return msize(k) < 2;
   endfunction

   task automatic mclear(input int k);
      case (k)
         0: mq0.delete();
         1: mq1.delete();
         default: mq2.delete();
      endcase
   endtask

   task automatic mpop(input int k);
      case (k)
         0: void'(mq0.pop_front());
         1: void'(mq1.pop_front());
         default: void'(mq2.pop_front());
      endcase
   endtask

   task automatic mpush(input int k, input ent_t en);
      case (k)
         0: mq0.push_back(en);
         1: mq1.push_back(en);
         default: mq2.push_back(en);
      endcase
   endtask

   task automatic model_update();
      for (int k = 0; k < 3; k++) begin
         int          sz;
         bit          ofire;
         bit          ifire;
         int unsigned cap;
         sz    = msize(k);
         ofire = (sz > 0) && (out_ready === 1'b1);
         ifire = (in_valid === 1'b1) && (mready(k) === 1'b1);
         cap   = (k == 1) ? 15 : 65535;
         if (reset) begin
            mclear(k);
            mcnt[k] = 0;
         end else begin
            if (sz > 0 && !out_ready && mcnt[k] < cap) mcnt[k] = mcnt[k] + 1;
            if (flush) begin
               mclear(k);
            end else begin
               if (ofire) mpop(k);
               if (ifire) mpush(k, {in_ctrl, in_data});
            end
         end
      end
   endtask

   function automatic obs_t expv(int k);
      obs_t e;
      ent_t h;
      e     = '0;
      h     = mhead(k);
      e.vld = msize(k) > 0;
      e.rdy = mready(k);
      if (e.vld) begin
         e.ctrl = h.ctrl;
         e.data = h.data;
      end
      e.cnt = 16'(mcnt[k]);
      return e;
   endfunction

   function automatic obs_t obsv(int k);
      obs_t o;
      o = '0;
      case (k)
         0: begin o.vld = dn0.valid; o.rdy = up0.ready; o.ctrl = dn0.ctrl; o.data = dn0.data; o.cnt = cnt0; end
         1: begin o.vld = dn1.valid; o.rdy = up1.ready; o.ctrl = dn1.ctrl; o.data = dn1.data; o.cnt = {12'd0, cnt1}; end
         default: begin o.vld = dn2.valid; o.rdy = up2.ready; o.ctrl = dn2.ctrl; o.data = dn2.data; o.cnt = cnt2; end
      endcase
      if (o.vld !== 1'b1) o.data = '0;
      return o;
   endfunction

   function automatic logic [159:0] raw_data(int k);
      if (k == 0) return dn0.data;
      if (k == 1) return dn1.data;
      return dn2.data;
   endfunction

   function automatic logic [159:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic drive(input logic v, input logic [159:0] d, input logic [4:0] c,
                        input logic ordy, input logic fl);
      in_valid  = v;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #2;
   endtask

   task automatic test_reset();
      obs_t o, e;
      reset = 1'b1;
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         o = obsv(k); e = expv(k);
         checks++;
         if (o !== e) begin failures++; $display("FAIL reset_state dut%0d got=%h want=%h", k, o, e); end
         checks++;
         if (raw_data(k) !== 160'd0) begin failures++; $display("FAIL reset_data dut%0d got=%h want=0", k, raw_data(k)); end
      end
      tick();
   endtask

   task automatic test_streaming();
      obs_t o, e;
      for (int i = 1; i <= 9; i++) begin
         if (i <= 8) drive(1'b1, 160'(i), 5'($urandom_range(31)), 1'b1, 1'b0);
         else        drive(1'b0, '0, '0, 1'b1, 1'b0);
         #1;
         o = obsv(0); e = expv(0);
         checks++;
         if (o !== e) begin failures++; $display("FAIL stream[%0d] got=%h want=%h", i, o, e); end
         if (i > 1) begin
            checks++;
            if (dn0.valid !== 1'b1 || dn0.data !== 160'(i - 1) || up0.ready !== 1'b1 || cnt0 !== 16'd0) begin
               failures++;
               $display("FAIL stream_seq[%0d] got vld=%b data=%h rdy=%b cnt=%0d want vld=1 data=%0h rdy=1 cnt=0",
                        i, dn0.valid, dn0.data, up0.ready, cnt0, i - 1);
            end
         end
         tick();
      end
   endtask

   task automatic test_skid_fill();
      obs_t o, e;
      for (int i = 0; i < 10; i++) begin
         case (i)
            0: drive(1'b1, 160'hA, 5'h01, 1'b0, 1'b0);
            1: drive(1'b1, 160'hB, 5'h02, 1'b0, 1'b0);
            2, 3, 4, 5: drive(1'b0, '0, '0, 1'b0, 1'b0);
            default: drive(1'b0, '0, '0, 1'b1, 1'b0);
         endcase
         #1;
         for (int k = 0; k < 3; k++) begin
            o = obsv(k); e = expv(k);
            checks++;
            if (o !== e) begin failures++; $display("FAIL skid_fill[%0d] dut%0d got=%h want=%h", i, k, o, e); end
         end
         if (i == 2 || i == 6) begin
            checks++;
            if (up0.ready !== 1'b0 || dn0.data !== 160'hA) begin
               failures++;
               $display("FAIL skid_full[%0d] got rdy=%b data=%h want rdy=0 data=a", i, up0.ready, dn0.data);
            end
         end
         if (i == 7) begin
            checks++;
            if (dn0.valid !== 1'b1 || dn0.data !== 160'hB) begin
               failures++;
               $display("FAIL skid_second got vld=%b data=%h want vld=1 data=b", dn0.valid, dn0.data);
            end
         end
         tick();
      end
   endtask

   task automatic test_flush_full();
      obs_t o, e;
      drive(1'b1, 160'h11, 5'h03, 1'b0, 1'b0); tick();
      drive(1'b1, 160'h22, 5'h04, 1'b0, 1'b0); tick();
      drive(1'b1, 160'h33, 5'h1F, 1'b0, 1'b1);
      #1;
      checks++;
      if (up0.ready !== 1'b0 || dn0.valid !== 1'b1) begin
         failures++; $display("FAIL flush_pre got rdy=%b vld=%b want rdy=0 vld=1", up0.ready, dn0.valid);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, '0, '0, 1'b0, 1'b0);
         #1;
         checks++;
         if (dn0.valid !== 1'b0 || dn0.ctrl !== 5'd0 || up0.ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_post[%0d] got vld=%b ctrl=%h rdy=%b want vld=0 ctrl=0 rdy=1",
                     i, dn0.valid, dn0.ctrl, up0.ready);
         end
         for (int k = 0; k < 3; k++) begin
            o = obsv(k); e = expv(k);
            checks++;
            if (o !== e) begin failures++; $display("FAIL flush_model[%0d] dut%0d got=%h want=%h", i, k, o, e); end
         end
         tick();
      end
   endtask

   task automatic test_saturation();
      obs_t o, e;
      int   want;
      reset = 1'b1;
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      tick();
      reset = 1'b0;
      drive(1'b1, 160'h44, 5'h05, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      for (int j = 1; j <= 20; j++) begin
         tick();
         want = (j < 15) ? j : 15;
         checks++;
         if (cnt1 !== 4'(want)) begin failures++; $display("FAIL sat_cnt[%0d] got=%0d want=%0d", j, cnt1, want); end
      end
      o = obsv(0); e = expv(0);
      checks++;
      if (o !== e) begin failures++; $display("FAIL sat_wide got=%h want=%h", o, e); end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      tick(); tick(); tick();
   endtask

   task automatic test_noskid_toggle();
      obs_t o, e;
      logic pat;
      for (int i = 0; i < 15; i++) begin
         pat = ((i % 3) != 1);
         drive(1'b1, 160'(32'h100 + i), 5'($urandom_range(31)), pat, 1'b0);
         #1;
         o = obsv(2); e = expv(2);
         checks++;
         if (o !== e) begin failures++; $display("FAIL noskid[%0d] got=%h want=%h", i, o, e); end
         tick();
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      tick(); tick(); tick();
   endtask

   task automatic test_random();
      obs_t o, e;
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(127) == 0);
         drive(($urandom_range(3) != 0), rand_data(), 5'($urandom_range(31)),
               ($urandom_range(2) != 0), ($urandom_range(31) == 0));
         #1;
         for (int k = 0; k < 3; k++) begin
            o = obsv(k); e = expv(k);
            checks++;
            if (o !== e) begin failures++; $display("FAIL random[%0d] dut%0d got=%h want=%h", i, k, o, e); end
         end
         tick();
      end
      reset = 1'b0;
   endtask

   task automatic test_reset_mid();
      obs_t o, e;
      drive(1'b1, 160'h55, 5'h06, 1'b0, 1'b0); tick();
      drive(1'b1, 160'h66, 5'h07, 1'b0, 1'b0); tick();
      reset = 1'b1;
      drive(1'b1, 160'h77, 5'h1F, 1'b1, 1'b1);
      tick();
      reset = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      checks++;
      if (dn0.valid !== 1'b0 || dn0.data !== 160'd0 || up0.ready !== 1'b1 || cnt0 !== 16'd0) begin
         failures++;
         $display("FAIL reset_mid got vld=%b data=%h rdy=%b cnt=%0d want vld=0 data=0 rdy=1 cnt=0",
                  dn0.valid, dn0.data, up0.ready, cnt0);
      end
      for (int k = 0; k < 3; k++) begin
         o = obsv(k); e = expv(k);
         checks++;
         if (o !== e) begin failures++; $display("FAIL reset_mid_model dut%0d got=%h want=%h", k, o, e); end
      end
      tick();
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      test_reset();
      test_streaming();
      test_skid_fill();
      test_flush_full();
      test_saturation();
      test_noskid_toggle();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, handshaked pipeline stage register that replaces fixed-field, write-enable stage registers such as the ID/EX register. It carries an opaque data bundle plus a control bundle (register-write, memory-write, mux selects, prediction bit) between two pipeline stages using valid/ready flow control. It supports an optional 2-entry skid buffer so the upstream ready path is registered. Flush inserts a bubble, and a stall counter is provided for performance monitoring.

## Interface
Parameters:
- DATA_W, 160, width of data bundle (PC, immediate, operands, register indices, opcode).
- CTRL_W, 5, width of control bundle; these bits are forced to 0 whenever the entry is not valid.
- SKID_EN, 1; 1 selects the 2-entry skid buffer with registered in_ready, 0 selects the single-entry mode.
- CNT_W, 16, width of the stall counter.

Ports:
- clk, in, 1, clock; all state changes on its rising edge.
- reset, in, 1, synchronous, active-high reset.
- flush, in, 1, discards all held entries and any same-cycle input.
- in_valid, in, 1, upstream entry valid.
- in_ready, out, 1, stage accepts an entry this cycle.
- in_data, in, DATA_W, upstream data bundle.
- in_ctrl, in, CTRL_W, upstream control bundle.
- out_valid, out, 1, head entry valid.
- out_ready, in, 1, downstream accepts the head entry.
- out_data, out, DATA_W, head data bundle.
- out_ctrl, out, CTRL_W, head control bundle; 0 when out_valid=0.
- stall_cnt, out, CNT_W, saturating count of stall cycles (out_valid=1 and out_ready=0).

## Operation
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (head) plus skid register. The skid register exists only when SKID_EN=1.

State machine (SKID_EN=1), states EMPTY, ONE, FULL:
- EMPTY: in_fire → ONE, main ← in.
- ONE, in_fire & out_fire → ONE, main ← in.
- ONE, in_fire & !out_fire → FULL, skid ← in.
- ONE, !in_fire & out_fire → EMPTY.
- ONE, neither → ONE, hold.
- FULL: out_fire → ONE, main ← skid. Otherwise hold. in_ready=0 in FULL, so no input is accepted.
- in_ready = (state != FULL), driven from a flop (no combinational path from out_ready).

Single-entry mode (SKID_EN=0):
- States are EMPTY and ONE only.
- in_ready = !out_valid | out_ready, which is combinational.
- in_fire loads main. out_fire without in_fire → EMPTY.

Outputs and flush:
- out_valid = (state != EMPTY). out_data and out_ctrl come from main.
- out_ctrl is gated to 0 when out_valid=0.
- flush has priority over every other event:
  - Next state is EMPTY.
  - The stored ctrl of both entries is zeroed.
  - Data registers hold their values.
  - A same-cycle in_fire is consumed and dropped.
- stall_cnt increments by 1 on each stall cycle, saturates at 2^CNT_W−1, and clears only on reset. flush does not clear it.

## Timing
- Reset (synchronous): state EMPTY, out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, skid cleared. From the first cycle after reset, in_ready=1.
- Latency: an entry accepted at edge N is visible at out_* after edge N, one cycle later. There is no combinational in→out path.
- Throughput: one entry per cycle while out_ready=1.
- Stall with SKID_EN=1: at most one extra entry is absorbed. in_ready falls the cycle after the skid register fills.
- Ordering: entries leave in acceptance order. The skid entry always follows the main entry.
- out_data and out_ctrl are stable while out_valid=1 and out_ready=0.
- reset asserted mid-transfer: all entries are lost and no out_fire is reported for that cycle's contents.
- flush together with reset: same effect as reset.

## Test plan
- Streaming: SKID_EN=1, out_ready=1, inputs 0x1..0x8 on consecutive cycles → out_data 0x1..0x8 one cycle later each, in_ready stays 1, stall_cnt=0.
- Skid fill: send 0xA then 0xB while out_ready=0 → FULL, in_ready=0 on the next cycle, stall_cnt counts. Release out_ready → 0xA, then 0xB, no loss or duplication.
- Flush in FULL, with in_valid=1 carrying ctrl=5'h1F → next cycle out_valid=0, out_ctrl=0, the input is dropped, and stall_cnt keeps its value.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt=15.
- SKID_EN=0: out_ready toggled 1,0,1 with continuous input → in_ready equals !out_valid | out_ready on every cycle, and order is preserved.
- Mid-operation reset in FULL → next cycle out_valid=0, out_data=0, in_ready=1, stall_cnt=0.
